mul_issue_ctrl: RTL and testbench

//  Issue/retire controller for the EX-stage pipelined multiplier (no enable, LAT-cycle latency).

---
 rtl/mul_issue_ctrl_pkg.sv | 35 +++
 rtl/mul_rsp_fifo.sv | 47 ++++
 rtl/mul_issue_ctrl.sv | 96 +++++++++
 tb/tb_mul_issue_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_issue_ctrl_pkg.sv
// Shared widths and helpers for the multiplier issue/retire controller.
// Holds the RegW/MulLat/MulTagW defaults; MUL_HI_EN widens operand and product paths.
`ifndef RegW
`define RegW 32
`endif
`ifndef MulLat
`define MulLat 2
`endif
`ifndef MulTagW
`define MulTagW 5
`endif

package mul_issue_ctrl_pkg;

  localparam int unsigned REG_W     = `RegW;
  localparam int unsigned MUL_LAT   = `MulLat;
  localparam int unsigned MUL_TAG_W = `MulTagW;
  localparam int unsigned MUL_DEPTH = 4;

`ifdef MUL_HI_EN
  localparam int unsigned OP_W = REG_W + 1;
  localparam int unsigned P_W  = 2 * REG_W;
`else
  localparam int unsigned OP_W = REG_W;
  localparam int unsigned P_W  = REG_W;
`endif

  typedef logic [REG_W-1:0] reg_t;

  // One extra bit lets a single signed multiplier serve both signed and unsigned requests.
  function automatic logic [REG_W:0] ext_op(input reg_t v, input logic sgn);
    return {sgn & v[REG_W-1], v};
  endfunction

endpackage

// File: rtl/mul_rsp_fifo.sv
// Synchronous result FIFO for the multiplier controller; clear drops all entries.
// Pointers wrap modulo Depth, so non-power-of-two depths are supported.
module mul_rsp_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                       CLK,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           wdata_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth+1)-1:0] cnt_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge CLK) begin
    if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop_i) begin
        rd_q <= ptr_inc(rd_q);
      end
      cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/retire controller for the pipelined EX-stage multiplier with credit-based issue.
// Define MUL_HI_EN to add high-half / signed multiply support.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int unsigned LAT   = MUL_LAT,
  parameter int unsigned DEPTH = MUL_DEPTH,
  parameter int unsigned TAGW  = MUL_TAG_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [REG_W-1:0] req_a_i,
  input  logic [REG_W-1:0] req_b_i,
  input  logic [TAGW-1:0]  req_tag_i,
`ifdef MUL_HI_EN
  input  logic             req_hi_i,
  input  logic             req_sgn_i,
`endif
  output logic [OP_W-1:0]  mul_a_o,
  output logic [OP_W-1:0]  mul_b_o,
  input  logic [P_W-1:0]   mul_p_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [REG_W-1:0] rsp_data_o,
  output logic [TAGW-1:0]  rsp_tag_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [LAT-1:0]   vld_q;
  logic [TAGW-1:0]  tag_q [LAT];
  logic [CntW-1:0]  inflight_q, fifo_cnt, used;
  logic             clr, accept, push, pop;
  logic [REG_W-1:0] push_data;

  assign clr         = RST | flush_i;
  assign used        = inflight_q + fifo_cnt;
  // Credit is taken from registered counts only, so ready never depends on this cycle's pop.
  assign req_ready_o = ~clr & (used < DepthC);
  assign accept      = req_valid_i & req_ready_o;
  assign push        = vld_q[LAT-1] & ~clr;
  assign pop         = rsp_valid_o & rsp_ready_i & ~flush_i;

`ifdef MUL_HI_EN
  logic [LAT-1:0] hi_q;

  assign mul_a_o   = accept ? ext_op(req_a_i, req_sgn_i) : '0;
  assign mul_b_o   = accept ? ext_op(req_b_i, req_sgn_i) : '0;
  assign push_data = hi_q[LAT-1] ? mul_p_i[P_W-1:REG_W] : mul_p_i[REG_W-1:0];

  always_ff @(posedge CLK) begin
    hi_q <= (hi_q << 1) | LAT'(req_hi_i);
  end
`else
  assign mul_a_o   = accept ? req_a_i : '0;
  assign mul_b_o   = accept ? req_b_i : '0;
  assign push_data = mul_p_i;
`endif

  always_ff @(posedge CLK) begin
    if (clr) begin
      vld_q      <= '0;
      inflight_q <= '0;
    end else begin
      vld_q      <= (vld_q << 1) | LAT'(accept);
      inflight_q <= inflight_q + CntW'(accept) - CntW'(vld_q[LAT-1]);
    end
    // Tags ride alongside vld and are only meaningful where vld is set.
    tag_q[0] <= req_tag_i;
    for (int i = 1; i < LAT; i++) begin
      tag_q[i] <= tag_q[i-1];
    end
  end

  mul_rsp_fifo #(
    .Depth (DEPTH),
    .Width (TAGW + REG_W)
  ) u_rsp_fifo (
    .CLK     (CLK),
    .clr_i   (clr),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({tag_q[LAT-1], push_data}),
    .rdata_o ({rsp_tag_o, rsp_data_o}),
    .cnt_o   (fifo_cnt)
  );

  assign rsp_valid_o = (fifo_cnt != '0) & ~RST;
  assign busy_o      = (used != '0) & ~RST;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: directed scenarios plus random traffic
// checked against a queue-based model of accepted requests and their ready times.
module tb_mul_issue_ctrl;
  import mul_issue_ctrl_pkg::*;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAGW  = 5;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             flush_i = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [REG_W-1:0] req_a_i = '0, req_b_i = '0;
  logic [TAGW-1:0]  req_tag_i = '0;
  logic [OP_W-1:0]  mul_a_o, mul_b_o;
  logic [P_W-1:0]   mul_p_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i = 1'b0;
  logic [REG_W-1:0] rsp_data_o;
  logic [TAGW-1:0]  rsp_tag_o;
  logic             busy_o;

  mul_issue_ctrl #(
    .LAT   (LAT),
    .DEPTH (DEPTH),
    .TAGW  (TAGW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_tag_i   (req_tag_i),
    .mul_a_o     (mul_a_o),
    .mul_b_o     (mul_b_o),
    .mul_p_i     (mul_p_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_tag_o   (rsp_tag_o),
    .busy_o      (busy_o)
  );

  always #5 CLK = ~CLK;

  // Multiplier model: LAT=2 pipeline, low half of the product.
  logic [REG_W-1:0] p1, p2;
  always @(posedge CLK) begin
    p1 <= mul_a_o * mul_b_o;
    p2 <= p1;
  end
  assign mul_p_i = p2;

  typedef struct {
    int unsigned      t;
    logic [REG_W-1:0] data;
    logic [TAGW-1:0]  tag;
  } ent_t;

  ent_t pend[$];
  ent_t avail[$];

  int unsigned      cyc = 0;
  int               checks = 0;
  int               errors = 0;
  int               obs_acc = 0;
  int               obs_rsp = 0;
  logic [REG_W-1:0] last_data;
  logic [TAGW-1:0]  last_tag;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", name, cyc, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    logic       exp_ready, exp_valid, acc, pop;
    logic [63:0] full;
    ent_t       e;
    @(negedge CLK);
    while (pend.size() > 0 && pend[0].t <= cyc) begin
      avail.push_back(pend[0]);
      pend.delete(0);
    end
    exp_ready = !RST && !flush_i && (pend.size() + avail.size() < DEPTH);
    exp_valid = !RST && (avail.size() > 0);
    acc       = req_valid_i && exp_ready;
    pop       = exp_valid && rsp_ready_i && !flush_i;
    chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
    chk("mul_a", 64'(mul_a_o), acc ? 64'(req_a_i) : 64'd0);
    chk("mul_b", 64'(mul_b_o), acc ? 64'(req_b_i) : 64'd0);
    chk("rsp_valid", 64'(rsp_valid_o), 64'(exp_valid));
    chk("busy", 64'(busy_o), 64'(!RST && (pend.size() + avail.size() > 0)));
    if (exp_valid && rsp_valid_o) begin
      chk("rsp_data", 64'(rsp_data_o), 64'(avail[0].data));
      chk("rsp_tag", 64'(rsp_tag_o), 64'(avail[0].tag));
    end
    if (req_valid_i && req_ready_o) obs_acc++;
    if (rsp_valid_o && rsp_ready_i && !flush_i) begin
      obs_rsp++;
      last_data = rsp_data_o;
      last_tag  = rsp_tag_o;
    end
    @(posedge CLK);
    if (RST || flush_i) begin
      pend.delete();
      avail.delete();
    end else begin
      if (pop) avail.delete(0);
      if (acc) begin
        full   = {32'd0, req_a_i} * {32'd0, req_b_i};
        e.t    = cyc + LAT + 1;
        e.data = full[REG_W-1:0];
        e.tag  = req_tag_i;
        pend.push_back(e);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    req_valid_i = v;
    req_a_i     = a;
    req_b_i     = b;
    req_tag_i   = tag;
  endtask

  int n0, r0, issued;

  initial begin
    #1;
    // Reset
    step();
    step();
    RST = 1'b0;
    rsp_ready_i = 1'b1;
    step();

    // Single op: 7*6 tag 3
    drive(1'b1, 32'd7, 32'd6, 5'd3);
    step();
    drive(1'b0, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 5; i++) step();
    chk("single_data", 64'(last_data), 64'd42);
    chk("single_tag", 64'(last_tag), 64'd3);

    // Back-to-back squares
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 32'(i), 5'(i - 1));
      step();
    end
    drive(1'b0, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 6; i++) step();
    chk("b2b_last", 64'(last_data), 64'd16);

    // Backpressure: credit stops at DEPTH accepts
    rsp_ready_i = 1'b0;
    n0 = obs_acc;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i + 10), 32'd3, 5'(i));
      step();
    end
    chk("bp_accepts", 64'(obs_acc - n0), 64'd4);
    drive(1'b0, 32'd0, 32'd0, 5'd0);
    rsp_ready_i = 1'b1;
    r0 = obs_rsp;
    for (int i = 0; i < 6; i++) step();
    chk("bp_rsps", 64'(obs_rsp - r0), 64'd4);

    // Truncation
    drive(1'b1, 32'hFFFF_FFFF, 32'd2, 5'd9);
    step();
    drive(1'b0, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 4; i++) step();
    chk("trunc", 64'(last_data), 64'hFFFF_FFFE);

    // Ten ops with toggling response ready to wrap the FIFO
    issued = 0;
    for (int i = 0; i < 30; i++) begin
      n0 = obs_acc;
      drive(issued < 10, $urandom, $urandom, 5'(issued));
      rsp_ready_i = i[0];
      step();
      issued += obs_acc - n0;
    end
    chk("wrap_issued", 64'(issued), 64'd10);
    drive(1'b0, 32'd0, 32'd0, 5'd0);
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Flush with two buffered and two in flight
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i + 2), 32'd5, 5'(i));
      step();
    end
    drive(1'b0, 32'd0, 32'd0, 5'd0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    rsp_ready_i = 1'b1;
    r0 = obs_rsp;
    for (int i = 0; i < 5; i++) step();
    chk("flush_no_rsp", 64'(obs_rsp - r0), 64'd0);

    // Reset mid-operation
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'(i + 3), 32'd3, 5'(i));
      step();
    end
    drive(1'b0, 32'd0, 32'd0, 5'd0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    r0 = obs_rsp;
    for (int i = 0; i < 5; i++) step();
    chk("rst_no_rsp", 64'(obs_rsp - r0), 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom_range(0, 31)));
      rsp_ready_i = $urandom_range(0, 2) != 0;
      flush_i     = $urandom_range(0, 40) == 0;
      RST         = $urandom_range(0, 100) == 0;
      step();
    end
    drive(1'b0, 32'd0, 32'd0, 5'd0);
    flush_i = 1'b0;
    RST = 1'b0;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
